regfile_mp: RTL and testbench

- Parametrised next-generation register file for the core.
- Width and depth are configurable. It provides two registered read ports and one write port.
- Register 0 is optionally hardwired to zero, and same-cycle write-to-read bypass is selectable.
- A reset-triggered clear sequencer zeroes every entry, so the pipeline never reads uninitialised state.
- Sits between decode (read) and writeback (write) in the CPU core.

---
 rtl/regfile_mp.sv | 132 +++++++++++++
 tb/tb_regfile_mp.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised register file: two registered read ports and one write port.
// On reset, a clear sequencer zeroes every entry before the file accepts traffic.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    output logic            init_busy,
    input  logic            rd_en,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            rvalid,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [AW:0] NREGS_EXT = (AW + 1)'(NREGS);
    localparam logic [AW:0] LAST_PTR  = (AW + 1)'(NREGS - 1);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

    state_t            state_q, state_d;
    logic [AW:0]       ptr_q, ptr_d;
    logic [XLEN-1:0]   rdata1_q, rdata1_d;
    logic [XLEN-1:0]   rdata2_q, rdata2_d;
    logic              rvalid_q, rvalid_d;
    logic [XLEN-1:0]   mem_q [NREGS];

    logic              wr_ok;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [XLEN-1:0]   mem_wdata;

    // The pointer is one bit wider than the address so range checks are exact for any NREGS.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < NREGS_EXT;
    endfunction

    function automatic logic [XLEN-1:0] port_read(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored,
        input logic            wr_hit,
        input logic [AW-1:0]   wr_addr,
        input logic [XLEN-1:0] wr_data
    );
        logic [XLEN-1:0] val;
        val = stored;
        if (!in_range(addr) || (ZERO_REG && addr == '0)) begin
            val = '0;
        end else if (BYPASS && wr_hit && wr_addr == addr) begin
            val = wr_data;
        end
        return val;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CLEAR;
            ptr_q    <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == CLEAR) begin
            ptr_d = ptr_q + PTR_ONE;
            if (ptr_q == LAST_PTR) begin
                state_d = READY;
            end
        end
    end

    always_comb begin
        init_busy = (state_q == CLEAR);
    end

    // Writes to register 0 (when hardwired) and past the end of the array are dropped.
    always_comb begin
        wr_ok     = we && (state_q == READY) && in_range(waddr)
                    && !(ZERO_REG && waddr == '0);
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q[AW-1:0];
            mem_wdata = '0;
        end else if (wr_ok) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        rvalid_d = 1'b0;
        if (state_q == READY && rd_en) begin
            rvalid_d = 1'b1;
            rdata1_d = port_read(rs1, mem_q[rs1], wr_ok, waddr, wdata);
            rdata2_d = port_read(rs2, mem_q[rs2], wr_ok, waddr, wdata);
        end
    end

    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations (32 regs / zero-reg / write-first and
// 24 regs / no zero-reg / read-first) share one stimulus stream and one array-level model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en;
    logic [4:0]  rs1, rs2, waddr;
    logic        we;
    logic [31:0] wdata;

    logic        busyA, rvA, busyB, rvB;
    logic [31:0] rd1A, rd2A, rd1B, rd2B;

    int testCount = 0;
    int failCount = 0;
    int cycle     = 0;

    // Per-instance configuration and reference state.
    int          nRegs [2] = '{32, 24};
    bit          zeroReg [2] = '{1'b1, 1'b0};
    bit          bypass [2] = '{1'b1, 1'b0};
    logic [31:0] model [2][32];
    int          clearLeft [2] = '{0, 0};
    logic        expBusy [2];
    logic        expRv [2];
    logic [31:0] expRd1 [2];
    logic [31:0] expRd2 [2];

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dutA (
        .clk(clk), .reset(reset), .init_busy(busyA),
        .rd_en(rd_en), .rs1(rs1), .rs2(rs2),
        .rdata1(rd1A), .rdata2(rd2A), .rvalid(rvA),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    regfile_mp #(.XLEN(32), .NREGS(24), .ZERO_REG(1'b0), .BYPASS(1'b0)) dutB (
        .clk(clk), .reset(reset), .init_busy(busyB),
        .rd_en(rd_en), .rs1(rs1), .rs2(rs2),
        .rdata1(rd1B), .rdata2(rd2B), .rvalid(rvB),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    function automatic bit writable(input int k, input int a);
        return (a < nRegs[k]) && !(zeroReg[k] && a == 0);
    endfunction

    function automatic logic [31:0] modelRead(input int k, input int a);
        if (a >= nRegs[k]) return 32'h0;
        if (zeroReg[k] && a == 0) return 32'h0;
        if (bypass[k] && we && int'(waddr) == a && writable(k, a)) return wdata;
        return model[k][a];
    endfunction

    // Advance one instance's model across the clock edge using the inputs held at that edge.
    task automatic modelEdge(input int k);
        if (reset) begin
            clearLeft[k] = nRegs[k];
            expRv[k]     = 1'b0;
            expRd1[k]    = 32'h0;
            expRd2[k]    = 32'h0;
        end else if (clearLeft[k] > 0) begin
            clearLeft[k]--;
            expRv[k] = 1'b0;
            if (clearLeft[k] == 0) begin
                for (int i = 0; i < 32; i++) model[k][i] = 32'h0;
            end
        end else begin
            if (rd_en) begin
                expRd1[k] = modelRead(k, int'(rs1));
                expRd2[k] = modelRead(k, int'(rs2));
                expRv[k]  = 1'b1;
            end else begin
                expRv[k] = 1'b0;
            end
            if (we && writable(k, int'(waddr))) model[k][waddr] = wdata;
        end
        expBusy[k] = (clearLeft[k] > 0);
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s cycle %0d observed=%h expected=%h", tag, cycle, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("A.init_busy", {31'h0, busyA}, {31'h0, expBusy[0]});
        checkVal("A.rvalid",    {31'h0, rvA},   {31'h0, expRv[0]});
        checkVal("A.rdata1",    rd1A,           expRd1[0]);
        checkVal("A.rdata2",    rd2A,           expRd2[0]);
        checkVal("B.init_busy", {31'h0, busyB}, {31'h0, expBusy[1]});
        checkVal("B.rvalid",    {31'h0, rvB},   {31'h0, expRv[1]});
        checkVal("B.rdata1",    rd1B,           expRd1[1]);
        checkVal("B.rdata2",    rd2B,           expRd2[1]);
    endtask

    task automatic applyStimulus(
        input logic        r,
        input logic        re,
        input logic [4:0]  a1,
        input logic [4:0]  a2,
        input logic        w,
        input logic [4:0]  wa,
        input logic [31:0] wd
    );
        reset = r; rd_en = re; rs1 = a1; rs2 = a2;
        we = w; waddr = wa; wdata = wd;
        @(posedge clk);
        #1;
        cycle++;
        modelEdge(0);
        modelEdge(1);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) model[k][i] = 32'h0;
        @(negedge clk);

        $display("[TB] reset held for two cycles");
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, 1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 32'hCAFE0000);

        $display("[TB] clear sequence with writes and reads that must be ignored");
        for (int i = 0; i < 34; i++)
            applyStimulus(1'b0, 1'b1, 5'(i), 5'(31 - i), 1'b1, 5'(i), 32'hA5A50000 + i);

        $display("[TB] read back every register");
        for (int i = 0; i < 32; i++)
            applyStimulus(1'b0, 1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0);

        $display("[TB] basic write and read");
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 32'h12345678);
        applyStimulus(1'b0, 1'b1, 5'd5, 5'd31, 1'b0, 5'd0, 32'h0);
        idle(1);

        $display("[TB] register zero");
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);

        $display("[TB] same-cycle write and read");
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h11);
        applyStimulus(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h22);
        applyStimulus(1'b0, 1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0);

        $display("[TB] address beyond the smaller array");
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd30, 32'h30303030);
        applyStimulus(1'b0, 1'b1, 5'd30, 5'd23, 1'b1, 5'd30, 32'h31313131);
        applyStimulus(1'b0, 1'b1, 5'd30, 5'd0, 1'b0, 5'd0, 32'h0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            logic [4:0] wa;
            logic [4:0] a1;
            logic [4:0] a2;
            wa = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), a1, a2,
                          1'($urandom_range(0, 1)), wa, $urandom);
        end

        $display("[TB] reset in the middle of a read");
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hAA);
        applyStimulus(1'b1, 1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0);
        idle(32);
        applyStimulus(1'b0, 1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 32'h0);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
